// File: rtl/enc_filter_pkg.sv
// Shared types and constants for the quadrature encoder input filter.
// The optional direction/step outputs are enabled by defining ENC_FILTER_DIR_EN.
package enc_filter_pkg;

  typedef enum logic {
    ENC_INIT = 1'b0,
    ENC_RUN  = 1'b1
  } enc_state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_CYCLES_DEF = 16;
  localparam int GLITCH_W_DEF    = 16;

  // Bits needed for a counter that spans 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Position of an A/B pair ([0]=A, [1]=B) along the forward sequence 00->01->11->10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    logic [1:0] idx;
    idx = 2'd0;
    case (ab)
      2'b00: idx = 2'd0;
      2'b01: idx = 2'd1;
      2'b11: idx = 2'd2;
      2'b10: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/enc_chan_filter.sv
// One encoder channel: synchroniser, stability-count debounce and glitch detect.
// Used twice by encoder_input_filter (ENC_FILTER_DIR_EN has no effect here).
module enc_chan_filter
  import enc_filter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic out_o,
  output logic commit_o,
  output logic glitch_o,
  output logic stable_o
);

  localparam int            CW      = cnt_width(FILT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   cand_q, cand_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_q, out_d;

  assign s = sync_q[SYNC_STAGES-1];

  // The candidate counts its own first sample as cnt==0, so a level seen for
  // FILT_CYCLES consecutive samples commits in the cycle cnt reaches the maximum.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    if (s != cand_q) begin
      cand_d = s;
      cnt_d  = '0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      if ((cnt_d == CNT_MAX) && (cand_q != out_q)) out_d = cand_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cand_q <= 1'b0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  // A pending level abandoned before commit: input fell back to the committed value.
  assign glitch_o = (cand_q != out_q) && (s == out_q);
  assign commit_o = (out_d != out_q);
  assign stable_o = (cnt_q == CNT_MAX);
  assign out_o    = out_q;

endmodule

// File: rtl/encoder_input_filter.sv
// Quadrature A/B conditioner: two channel filters, INIT/RUN FSM, illegal-step flags,
// saturating glitch counter. Define ENC_FILTER_DIR_EN to add step_o/dir_o.
module encoder_input_filter
  import enc_filter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF,
  parameter int GLITCH_W    = GLITCH_W_DEF
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [1:0]          enc_raw_in,
  input  logic                err_clr_i,
  output logic [1:0]          enc_clean_out,
  output logic                illegal_step_o,
  output logic                err_sticky_o,
  output logic [GLITCH_W-1:0] glitch_cnt_o,
`ifdef ENC_FILTER_DIR_EN
  output logic                step_o,
  output logic                dir_o,
`endif
  output enc_state_e          state_o
);

  logic [1:0] chan_out, chan_commit, chan_glitch, chan_stable;

  for (genvar g = 0; g < 2; g++) begin : g_chan
    enc_chan_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES)
    ) u_chan (
      .clk_i   (clk_clk),
      .rst_ni  (reset_reset_n),
      .raw_i   (enc_raw_in[g]),
      .out_o   (chan_out[g]),
      .commit_o(chan_commit[g]),
      .glitch_o(chan_glitch[g]),
      .stable_o(chan_stable[g])
    );
  end

  enc_state_e          state_q, state_d;
  logic                illegal_q, illegal_d;
  logic                sticky_q, sticky_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic [1:0]          glitch_inc;
  logic [GLITCH_W:0]   glitch_sum;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ENC_INIT: if (&chan_stable) state_d = ENC_RUN;
      ENC_RUN:  state_d = ENC_RUN;
      default:  state_d = ENC_INIT;
    endcase
  end

  // Power-up commits happen in INIT, so a 00->11 first level never flags.
  always_comb begin
    illegal_d = (state_q == ENC_RUN) && (&chan_commit);
    sticky_d  = sticky_q;
    if (illegal_d)      sticky_d = 1'b1;
    else if (err_clr_i) sticky_d = 1'b0;
  end

  assign glitch_inc = {1'b0, chan_glitch[0]} + {1'b0, chan_glitch[1]};
  assign glitch_sum = {1'b0, glitch_q} + (GLITCH_W + 1)'(glitch_inc);
  assign glitch_d   = glitch_sum[GLITCH_W] ? '1 : glitch_sum[GLITCH_W-1:0];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= ENC_INIT;
      illegal_q <= 1'b0;
      sticky_q  <= 1'b0;
      glitch_q  <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      sticky_q  <= sticky_d;
      glitch_q  <= glitch_d;
    end
  end

`ifdef ENC_FILTER_DIR_EN
  logic       step_q, step_d;
  logic       dir_q, dir_d;
  logic [1:0] out_next;

  assign out_next = chan_out ^ chan_commit;

  // Exactly one bit committing in RUN is a legal quadrature step.
  always_comb begin
    step_d = (state_q == ENC_RUN) && (^chan_commit);
    dir_d  = dir_q;
    if (step_d) dir_d = (gray_idx(out_next) == (gray_idx(chan_out) + 2'd1));
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      step_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      step_q <= step_d;
      dir_q  <= dir_d;
    end
  end

  assign step_o = step_q;
  assign dir_o  = dir_q;
`endif

  assign enc_clean_out  = chan_out;
  assign illegal_step_o = illegal_q;
  assign err_sticky_o   = sticky_q;
  assign glitch_cnt_o   = glitch_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_encoder_input_filter.sv
// Bench for encoder_input_filter: run-length reference model checked every cycle,
// directed latency/glitch/sticky steps, plus a GLITCH_W=4 saturation instance.
module tb_encoder_input_filter;
  import enc_filter_pkg::*;

  localparam int S  = 2;
  localparam int F  = 16;
  localparam int GW = 16;

  // ---------------- clock / reset ----------------
  logic clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  logic          reset_reset_n = 1'b0;
  logic [1:0]    enc_raw_in    = 2'b00;
  logic          err_clr_i     = 1'b0;
  logic [1:0]    enc_clean_out;
  logic          illegal_step_o, err_sticky_o;
  logic [GW-1:0] glitch_cnt_o;
  enc_state_e    state_o;

  logic [1:0]    raw_g = 2'b00;
  logic          clr_g = 1'b0;
  logic [1:0]    clean_g;
  logic          ill_g, sticky_g;
  logic [3:0]    glitch_g;
  enc_state_e    state_g;

`ifdef ENC_FILTER_DIR_EN
  logic step_o, dir_o, step_g, dir_g;
`endif

  encoder_input_filter dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enc_raw_in(enc_raw_in),
    .err_clr_i(err_clr_i), .enc_clean_out(enc_clean_out), .illegal_step_o(illegal_step_o),
    .err_sticky_o(err_sticky_o), .glitch_cnt_o(glitch_cnt_o),
`ifdef ENC_FILTER_DIR_EN
    .step_o(step_o), .dir_o(dir_o),
`endif
    .state_o(state_o)
  );

  encoder_input_filter #(.GLITCH_W(4)) dut_g4 (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enc_raw_in(raw_g),
    .err_clr_i(clr_g), .enc_clean_out(clean_g), .illegal_step_o(ill_g),
    .err_sticky_o(sticky_g), .glitch_cnt_o(glitch_g),
`ifdef ENC_FILTER_DIR_EN
    .step_o(step_g), .dir_o(dir_g),
`endif
    .state_o(state_g)
  );

  // ---------------- reference model ----------------
  // Each channel tracks how many consecutive synchronised samples of the same level
  // it has seen; a level seen F times in a row that differs from the output is adopted.
  int         vectors     = 0;
  int         miscompares = 0;
  logic [1:0] pipe_m [S];
  logic [1:0] val_m, out_m;
  int         run_m [2];
  logic       run_state_m, ill_m, sticky_m, step_m, dir_m;
  int         glitch_m;

  function automatic int gidx(input logic [1:0] ab);
    int r;
    r = 0;
    if (ab == 2'b01) r = 1;
    if (ab == 2'b11) r = 2;
    if (ab == 2'b10) r = 3;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < S; i++) pipe_m[i] = 2'b00;
    val_m = 2'b00; out_m = 2'b00;
    run_m[0] = 1; run_m[1] = 1;
    run_state_m = 1'b0; ill_m = 1'b0; sticky_m = 1'b0;
    step_m = 1'b0; dir_m = 1'b0; glitch_m = 0;
  endtask

  task automatic model_tick(input logic [1:0] raw, input logic clr);
    logic [1:0] s, commit;
    logic       both_stable, was_run;
    int         g;
    s = pipe_m[S-1];
    for (int i = S - 1; i > 0; i--) pipe_m[i] = pipe_m[i-1];
    pipe_m[0] = raw;
    both_stable = (run_m[0] >= F) && (run_m[1] >= F);
    was_run = run_state_m;
    commit = 2'b00;
    g = 0;
    for (int c = 0; c < 2; c++) begin
      if ((s[c] == out_m[c]) && (val_m[c] != out_m[c])) g++;
      if (s[c] != val_m[c]) begin
        val_m[c] = s[c];
        run_m[c] = 1;
      end else if (run_m[c] < F) run_m[c]++;
      if ((run_m[c] == F) && (val_m[c] != out_m[c])) commit[c] = 1'b1;
    end
    ill_m = was_run && (commit == 2'b11);
    if (ill_m) sticky_m = 1'b1;
    else if (clr) sticky_m = 1'b0;
    step_m = was_run && ((commit == 2'b01) || (commit == 2'b10));
    if (step_m) dir_m = (gidx(out_m ^ commit) == ((gidx(out_m) + 1) % 4));
    out_m = out_m ^ commit;
    glitch_m = glitch_m + g;
    if (glitch_m > (1 << GW) - 1) glitch_m = (1 << GW) - 1;
    if (!was_run && both_stable) run_state_m = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".clean"},  32'(enc_clean_out),  32'(out_m));
    chk({tag, ".illegal"}, 32'(illegal_step_o), 32'(ill_m));
    chk({tag, ".sticky"}, 32'(err_sticky_o),   32'(sticky_m));
    chk({tag, ".glitch"}, 32'(glitch_cnt_o),   32'(glitch_m));
    chk({tag, ".run"},    32'(state_o == ENC_RUN), 32'(run_state_m));
`ifdef ENC_FILTER_DIR_EN
    chk({tag, ".step"},   32'(step_o), 32'(step_m));
    chk({tag, ".dir"},    32'(dir_o),  32'(dir_m));
`endif
  endtask

  // ---------------- drivers (start and end on a falling edge) ----------------
  task automatic tick(input logic [1:0] raw, input logic clr, input string tag);
    enc_raw_in = raw;
    err_clr_i  = clr;
    @(posedge clk_clk);
    model_tick(raw, clr);
    #1;
    check_all(tag);
    @(negedge clk_clk);
  endtask

  task automatic hold(input logic [1:0] raw, input int n, input string tag);
    for (int i = 0; i < n; i++) tick(raw, 1'b0, tag);
  endtask

  task automatic do_reset(input logic [1:0] raw, input string tag);
    reset_reset_n = 1'b0;
    enc_raw_in    = raw;
    err_clr_i     = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk({tag, ".rst_clean"},  32'(enc_clean_out),  32'd0);
      chk({tag, ".rst_ill"},    32'(illegal_step_o), 32'd0);
      chk({tag, ".rst_sticky"}, 32'(err_sticky_o),   32'd0);
      chk({tag, ".rst_glitch"}, 32'(glitch_cnt_o),   32'd0);
      chk({tag, ".rst_state"},  32'(state_o == ENC_INIT), 32'd1);
      @(negedge clk_clk);
    end
    reset_reset_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int   lat, ill_pulses, g_before, g4_exp;
    logic [1:0] r;
    logic       saw_ill;

    // 1: power-up with both pins high commits 11 after 18 cycles, no illegal flag
    do_reset(2'b11, "t1");
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      tick(2'b11, 1'b0, "t1");
      if ((lat < 0) && (enc_clean_out == 2'b11)) lat = k;
    end
    chk("t1.latency", 32'(lat), 32'd18);

    // back to 00 in RUN is a double-bit change; clear the sticky afterwards
    hold(2'b00, 25, "t1b");
    tick(2'b00, 1'b1, "t1b.clr");

    // 2: A rises from 00 in RUN
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      tick(2'b01, 1'b0, "t2");
      if ((lat < 0) && (enc_clean_out == 2'b01)) lat = k;
    end
    chk("t2.latency", 32'(lat), 32'd18);

    // 3: 5-cycle B pulse is rejected and counted once
    g_before = glitch_m;
    hold(2'b11, 5, "t3");
    hold(2'b01, 20, "t3");
    chk("t3.glitch_inc", 32'(glitch_cnt_o), 32'(g_before + 1));
    chk("t3.clean_kept", 32'(enc_clean_out), 32'h1);

    // 4: illegal 00->11, sticky clear, then clear coincident with a new illegal step
    hold(2'b00, 20, "t4a");
    ill_pulses = 0;
    for (int k = 0; k < 22; k++) begin
      tick(2'b11, 1'b0, "t4b");
      if (illegal_step_o) ill_pulses++;
    end
    chk("t4.pulses", 32'(ill_pulses), 32'd1);
    chk("t4.sticky_set", 32'(err_sticky_o), 32'd1);
    tick(2'b11, 1'b1, "t4c");
    chk("t4.sticky_clr", 32'(err_sticky_o), 32'd0);
    hold(2'b00, 17, "t4d");
    tick(2'b00, 1'b1, "t4d.coinc");
    chk("t4.set_wins", 32'(err_sticky_o), 32'd1);
    hold(2'b00, 5, "t4e");

    // random segments of random length with occasional clears
    for (int seg = 0; seg < 40; seg++) begin
      r = 2'($urandom_range(0, 3));
      for (int k = 0; k < $urandom_range(1, 30); k++)
        tick(r, ($urandom_range(0, 9) == 0), "rnd");
    end

    // 6: reset in the middle of a pending A level, next commit happens in INIT
    hold(2'b00, 20, "t6a");
    hold(2'b01, 12, "t6b");
    do_reset(2'b01, "t6");
    saw_ill = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick(2'b11, 1'b0, "t6c");
      if (illegal_step_o) saw_ill = 1'b1;
    end
    chk("t6.no_illegal", 32'(saw_ill), 32'd0);
    chk("t6.clean", 32'(enc_clean_out), 32'h3);

    // 5: GLITCH_W=4 instance saturates at 15
    for (int p = 0; p < 20; p++) begin
      raw_g = 2'b01;
      hold(2'b11, 3, "t5");
      raw_g = 2'b00;
      hold(2'b11, 8, "t5");
      g4_exp = (p + 1 > 15) ? 15 : p + 1;
      chk("t5.g4_count", 32'(glitch_g), 32'(g4_exp));
    end
    chk("t5.g4_clean", 32'(clean_g), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
